// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared OFDM constants, bank-state encoding and the fftshift address map
package ofdm_pkg;
  localparam int N_FFT = 256;
  localparam int LOG2N = 8;
  localparam int DW    = 32;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  function automatic logic [LOG2N-1:0] fftshift_addr(input logic [LOG2N-1:0] cnt);
    return {~cnt[LOG2N-1], cnt[LOG2N-2:0]};
  endfunction
endpackage

// File: rtl/subcarrier_reorder_if.sv
// subcarrier_reorder_if: input and output stream handshakes of the reorder stage
interface subcarrier_reorder_if #(parameter int DW = 32);
  logic [DW-1:0] DAT_I;
  logic          CYC_I;
  logic          WE_I;
  logic          STB_I;
  logic          ACK_O;
  logic [DW-1:0] DAT_O;
  logic          CYC_O;
  logic          STB_O;
  logic          WE_O;
  logic          ACK_I;

  modport master (output DAT_I, CYC_I, WE_I, STB_I, ACK_I,
                  input  ACK_O, DAT_O, CYC_O, STB_O, WE_O);
  modport slave  (input  DAT_I, CYC_I, WE_I, STB_I, ACK_I,
                  output ACK_O, DAT_O, CYC_O, STB_O, WE_O);
endinterface

// File: rtl/pp_ram.sv
// pp_ram: two-bank simple dual-port RAM, synchronous write, registered read with clear
module pp_ram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/subcarrier_reorder.sv
// subcarrier_reorder: ping-pong buffer that turns natural-order symbols into fftshift order
module subcarrier_reorder
  import ofdm_pkg::*;
#(
  parameter int DW    = ofdm_pkg::DW,
  parameter int LOG2N = ofdm_pkg::LOG2N
) (
  input logic                 CLK_I,
  input logic                 RST_I,
  subcarrier_reorder_if.slave bus
);
  localparam logic [LOG2N-1:0] LAST = '1;

  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_ptr;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic             icyc_q, stb_q, stb_d, cyc_q, cyc_d;
  logic             ena, ack, load, start, stop, wr_last, rd_last, idle;
  logic [DW-1:0]    rdata;

  always_comb begin
    ena     = bus.CYC_I & bus.STB_I & bus.WE_I;
    start   = bus.CYC_I & ~icyc_q;
    stop    = ~bus.CYC_I & icyc_q;
    ack     = ena & (bank_q[wr_bank_q] inside {EMPTY, FILLING});
    load    = (bank_q[rd_bank_q] inside {FULL, DRAINING}) & (~stb_q | bus.ACK_I);
    wr_ptr  = start ? '0 : wr_cnt_q;
    wr_last = wr_ptr == LAST;
    rd_last = rd_cnt_q == LAST;
    idle    = ~bus.CYC_I & (bank_q[0] == EMPTY) & (bank_q[1] == EMPTY);
    bank_d  = bank_q;
    // a stream edge abandons any half-written symbol
    for (int i = 0; i < 2; i++)
      if ((start | stop) && bank_q[i] == FILLING) bank_d[i] = EMPTY;
    wr_cnt_d  = (start | stop) ? '0 : wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (ack) begin
      bank_d[wr_bank_q] = wr_last ? FULL : FILLING;
      wr_cnt_d          = wr_ptr + 1'b1;
      wr_bank_d         = wr_bank_q ^ wr_last;
    end
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (load) begin
      bank_d[rd_bank_q] = rd_last ? EMPTY : DRAINING;
      rd_cnt_d          = rd_cnt_q + 1'b1;
      rd_bank_d         = rd_bank_q ^ rd_last;
    end
    stb_d = load | (stb_q & ~bus.ACK_I);
    cyc_d = load | (cyc_q & ~((~stb_q | bus.ACK_I) & idle));
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      bank_q    <= '{default: EMPTY};
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      icyc_q    <= 1'b0;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      icyc_q    <= bus.CYC_I;
      stb_q     <= stb_d;
      cyc_q     <= cyc_d;
    end
  end

  pp_ram #(.DW(DW), .AW(LOG2N + 1)) u_ram (
    .clk  (CLK_I),
    .rst_n(RST_I),
    .we   (ack),
    .waddr({wr_bank_q, wr_ptr}),
    .wdata(bus.DAT_I),
    .re   (load),
    .raddr({rd_bank_q, fftshift_addr(rd_cnt_q)}),
    .rdata(rdata)
  );

  assign bus.ACK_O = ack;
  assign bus.DAT_O = rdata;
  assign bus.STB_O = stb_q;
  assign bus.WE_O  = stb_q;
  assign bus.CYC_O = cyc_q;
endmodule

// File: tb/tb_subcarrier_reorder.sv
// tb_subcarrier_reorder: randomized scoreboard bench for the fftshift reorder stage
module tb_subcarrier_reorder;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  subcarrier_reorder_if #(.DW(32)) bus ();
  subcarrier_reorder dut (.CLK_I(clk), .RST_I(rst_n), .bus(bus));

  int          n_chk = 0, n_fail = 0, cyc = 0, stalls = 0, last_ack_cyc = 0, ack_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sym_q[$];
  int          pop_cyc[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_dat = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: bus.ACK_I = 1'b1;
      1: bus.ACK_I = (cyc % 4) == 0;
      default: bus.ACK_I = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: every downstream transfer is popped against the model's queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        check("hold_stb", {31'b0, bus.STB_O}, 32'd1);
        check("hold_dat", bus.DAT_O, prev_dat);
      end
      if (bus.STB_O) begin
        check("we_o", {31'b0, bus.WE_O}, 32'd1);
        check("cyc_o_high", {31'b0, bus.CYC_O}, 32'd1);
      end
      if (bus.STB_O && bus.ACK_I) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no word", bus.DAT_O);
        end else check("data", bus.DAT_O, exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
      prev_hold = bus.STB_O & ~bus.ACK_I;
      prev_dat  = bus.DAT_O;
    end else prev_hold = 1'b0;
  end

  task automatic accept(input logic [31:0] d);
    sym_q.push_back(d);
    last_ack_cyc = cyc;
    if (sym_q.size() == N) begin
      for (int k = 0; k < N; k++) exp_q.push_back(sym_q[k ^ (N / 2)]);
      sym_q.delete();
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    bus.DAT_I = d;
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.ACK_O) break;
      stalls++;
      if (t > 5000) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: got no ACK_O expected ACK_O within 5000 cycles");
        $fatal(1, "input side stuck");
      end
      @(posedge clk);
      #1;
    end
    accept(d);
    @(posedge clk);
    #1;
    bus.STB_I = 1'b0;
  endtask

  task automatic gate_cycle();
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b0;
    @(negedge clk);
    check("we_gate", {31'b0, bus.ACK_O}, 32'd0);
    @(posedge clk);
    #1;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b1;
  endtask

  task automatic send_symbol(input int base, input bit rnd, input bit gaps, input int len);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) gate_cycle();
      if (gaps && $urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      send_word(rnd ? $urandom : 32'(base + i));
    end
  endtask

  task automatic start_stream();
    bus.CYC_I = 1'b1;
  endtask

  task automatic end_stream();
    bus.CYC_I = 1'b0;
    sym_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.STB_O) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int target);
    int t = 0;
    while (pop_cyc.size() < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_chk++;
      n_fail++;
      $display("FAIL pop_timeout: got %0d outputs expected %0d", pop_cyc.size(), target);
    end
  endtask

  initial begin
    int          base, t;
    logic        s, c;
    logic [31:0] d;
    bus.DAT_I = '0;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ACK_I = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stb", {31'b0, bus.STB_O}, 32'd0);
    check("rst_cyc", {31'b0, bus.CYC_O}, 32'd0);
    check("rst_dat", bus.DAT_O, 32'd0);
    check("rst_ack", {31'b0, bus.ACK_O}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ramp: order, latency and CYC_O release
    base = pop_cyc.size();
    start_stream();
    send_symbol(0, 1'b0, 1'b0, N);
    end_stream();
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("ramp_stb_end", {31'b0, bus.STB_O}, 32'd0);
    check("ramp_cyc_drop", {31'b0, bus.CYC_O}, 32'd0);
    if (pop_cyc.size() > base) check("latency", 32'(pop_cyc[base] - last_ack_cyc), 32'd2);
    else check("ramp_count", 32'(pop_cyc.size() - base), 32'(N));
    drain();

    // streaming: three back-to-back symbols without input stalls or output gaps
    stalls = 0;
    base = pop_cyc.size();
    start_stream();
    for (int s_i = 0; s_i < 3; s_i++) send_symbol(s_i * N, 1'b0, 1'b0, N);
    end_stream();
    drain();
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_count", 32'(pop_cyc.size() - base), 32'(3 * N));
    if (pop_cyc.size() >= base + 3 * N)
      check("stream_gap", 32'(pop_cyc[base+3*N-1] - pop_cyc[base]), 32'(3 * N - 1));

    // backpressure: downstream takes one word in four
    ack_mode = 1;
    stalls = 0;
    base = pop_cyc.size();
    start_stream();
    for (int s_i = 0; s_i < 4; s_i++) send_symbol(0, 1'b1, 1'b0, N);
    end_stream();
    drain();
    check("bp_stall_seen", {31'b0, stalls > 0}, 32'd1);
    check("bp_count", 32'(pop_cyc.size() - base), 32'(4 * N));
    ack_mode = 0;

    // partial symbol is discarded, next full symbol survives
    base = pop_cyc.size();
    start_stream();
    send_symbol(0, 1'b1, 1'b0, 100);
    end_stream();
    start_stream();
    send_symbol(32'h5000, 1'b0, 1'b0, N);
    end_stream();
    drain();
    check("partial_count", 32'(pop_cyc.size() - base), 32'(N));

    // synchronous reset in the middle of a drain
    base = pop_cyc.size();
    start_stream();
    send_symbol(0, 1'b1, 1'b0, N);
    end_stream();
    wait_pops(base + 50);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    sym_q.delete();
    check("mid_rst_stb", {31'b0, bus.STB_O}, 32'd0);
    check("mid_rst_cyc", {31'b0, bus.CYC_O}, 32'd0);
    check("mid_rst_dat", bus.DAT_O, 32'd0);
    base = pop_cyc.size();
    start_stream();
    send_symbol(32'h1000, 1'b0, 1'b0, N);
    end_stream();
    drain();
    check("post_rst_count", 32'(pop_cyc.size() - base), 32'(N));

    // RST_I low between edges must not disturb anything
    base = pop_cyc.size();
    start_stream();
    send_symbol(0, 1'b1, 1'b0, N);
    end_stream();
    wait_pops(base + 30);
    @(posedge clk);
    #1;
    s = bus.STB_O;
    c = bus.CYC_O;
    d = bus.DAT_O;
    rst_n = 1'b0;
    #2;
    check("async_stb", {31'b0, bus.STB_O}, {31'b0, s});
    check("async_cyc", {31'b0, bus.CYC_O}, {31'b0, c});
    check("async_dat", bus.DAT_O, d);
    rst_n = 1'b1;
    drain();
    check("nrst_count", 32'(pop_cyc.size() - base), 32'(N));

    // random backpressure, random input gaps and write-qualifier gating
    ack_mode = 2;
    start_stream();
    for (int s_i = 0; s_i < 2; s_i++) send_symbol(0, 1'b1, 1'b1, N);
    end_stream();
    drain();
    ack_mode = 0;

    check("final_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/subcarrier_reorder.md
Name: subcarrier_reorder

Overview:
- Stage directly downstream of pilot insertion, directly upstream of the 256-point IFFT.
- Input: one OFDM symbol per 256 words, in natural frequency order, i.e. lowest guard subcarrier first.
- Output: the same words in IFFT input order, i.e. fftshift. Output index k carries input index k XOR 128, so DC comes first.
- Ping-pong double buffer: one bank fills while the other drains, so continuous streaming needs no input stalls.

Parameters:
- DW, 32, data width ({Im[15:0], Re[15:0]} Q1.15).
- LOG2N, 8, log2 of the symbol length. N = 2^LOG2N = 256.

Ports:
- CLK_I  in  1  clock; all logic on the rising edge.
- RST_I  in  1  synchronous reset, active-low. Active when 0 on a rising edge.
- DAT_I  in  DW  input sample.
- CYC_I  in  1  input stream active. A rising edge starts a new stream.
- WE_I  in  1  write qualifier.
- STB_I  in  1  input word valid.
- ACK_O  out  1  input word accepted this cycle.
- DAT_O  out  DW  reordered sample, registered.
- CYC_O  out  1  output stream active, registered.
- STB_O  out  1  output word valid, registered.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream accepts DAT_O this cycle.

Behaviour:
- Reset (RST_I=0) values:
  - STB_O=0, CYC_O=0, DAT_O=0.
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0.
  - Both banks EMPTY; icyc=0.
  - Reset mid-symbol discards all buffered data. Reset overrides every other event.
- Storage: 2 banks x N x DW. Write port is synchronous. The read address feeds the DAT_O register, so there is one register stage and no extra RAM latency.
- Bank state: one per bank, EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Input side:
  - ena = CYC_I & STB_I & WE_I.
  - ACK_O = ena & (bank[wr_bank] is EMPTY or FILLING).
  - On ACK_O: mem[wr_bank][wr_cnt] <= DAT_I; wr_cnt++.
  - When wr_cnt==N-1 on ACK_O: bank[wr_bank] becomes FULL, wr_bank toggles, wr_cnt wraps to 0.
- Stream start: icyc is CYC_I registered. CYC_I & ~icyc sets wr_cnt=0 and sets any FILLING bank to EMPTY. FULL and DRAINING banks are untouched.
- Partial symbol: when CYC_I falls with wr_cnt != 0, the FILLING bank is discarded (set EMPTY, wr_cnt=0). Partial symbols are never output.
- Output side:
  - load = bank[rd_bank] in {FULL, DRAINING} & (~STB_O | ACK_I).
  - On load: DAT_O <= mem[rd_bank][{~rd_cnt[LOG2N-1], rd_cnt[LOG2N-2:0]}]; STB_O <= 1; rd_cnt++; bank becomes DRAINING.
  - Load of rd_cnt==N-1: bank becomes EMPTY at the same edge, rd_bank toggles, rd_cnt wraps.
  - No load & ACK_I: STB_O <= 0.
  - While STB_O & ~ACK_I: DAT_O and STB_O hold.
- Simultaneous events:
  - Release by the reader and the writer's first ACK into the same bank: the bank is EMPTY in the following cycle, so the writer is accepted then. With ACK_I=1, ACK_O never drops on continuous input after the first symbol.
  - Writer completing bank A in the same cycle the reader completes bank B: both updates apply.
- Latency: the first output word has STB_O=1 two cycles after the ACK_O cycle of the symbol's last input word.
- CYC_O:
  - Set on the first load of a stream.
  - Cleared the cycle after the final output word is acknowledged, when CYC_I=0 and both banks are EMPTY.
  - Stays high across back-to-back symbols.
- Width: data passes unmodified. No arithmetic. Counters are LOG2N bits and wrap naturally.

Decomposition:
- Shared package ofdm_pkg:
  - constants N_FFT=256, LOG2N=8, DW=32.
  - bank-state enum {EMPTY, FILLING, FULL, DRAINING}.
  - function fftshift_addr(cnt).
- One sub-module: pp_ram, a 2xN x DW simple dual-port RAM with write enable, write address, read address, registered read.
- The control FSM and counters stay in the top module.

Test Plan:
- Ramp: single symbol DAT_I=0..255, ACK_I=1.
  -> DAT_O sequence 128..255 then 0..127.
  -> First STB_O 2 cycles after last ACK_O.
  -> CYC_O drops after word 127.
- Streaming: 3 back-to-back symbols (value = sym*256+idx), STB_I and ACK_I held 1.
  -> ACK_O continuously 1 after cycle 0.
  -> 768 outputs in correct shifted order, with no gap between symbols.
- Backpressure: ACK_I 1-of-4 pattern while 4 symbols are streamed.
  -> ACK_O drops once both banks are FULL/DRAINING.
  -> DAT_O stable while STB_O & ~ACK_I.
  -> No word lost or duplicated.
- Partial symbol: CYC_I falls after 100 words, then a full symbol follows.
  -> The 100 words never appear.
  -> The next symbol is output correctly.
- Reset: RST_I=0 for 1 cycle mid-drain (rd_cnt=50).
  -> Next cycle STB_O=0, CYC_O=0, DAT_O=0.
  -> A following full symbol outputs correctly from index 128.
- Reset polarity: RST_I held 1 with no clock edge effect.
  -> No reset occurs.
  -> RST_I=0 without a clock edge changes no output (synchronous).
